// File: rtl/pie_pkg.sv
// Shared encodings for the PIE transmit encoder: FSM states, symbol kinds and
// the default duration/timer width.
package pie_pkg;

    localparam int CNT_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELIM = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SYM_DATA0 = 2'd0,
        SYM_RTCAL = 2'd1,
        SYM_TRCAL = 2'd2,
        SYM_DATA  = 2'd3
    } sym_t;

endpackage

// File: rtl/pie_symbol_timer.sv
// Loadable down-counter timing one FSM state: load duration-1 on entry, the
// state ends on the cycle the count reads zero.
module pie_symbol_timer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic [CNT_WIDTH-1:0] value,
    output logic                 expire
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value  = cnt_q;
    assign expire = (cnt_q == '0);

endmodule

// File: rtl/pie_encoder.sv
// Reader-to-tag PIE envelope encoder: delimiter, DATA0, RTcal, optional TRcal,
// then one data symbol per command bit fed through a one-entry hold register.
module pie_encoder
    import pie_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_WIDTH-1:0] cfg_delim,
    input  logic [CNT_WIDTH-1:0] cfg_tari,
    input  logic [CNT_WIDTH-1:0] cfg_data1,
    input  logic [CNT_WIDTH-1:0] cfg_rtcal,
    input  logic [CNT_WIDTH-1:0] cfg_trcal,
    input  logic [CNT_WIDTH-1:0] cfg_pw,
    input  logic                 start,
    input  logic                 preamble,
    input  logic                 bit_dat,
    input  logic                 bit_vld,
    input  logic                 bit_last,
    output logic                 bit_rdy,
    output logic                 tx_mod,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Duration d lasts max(d,1) cycles, so the timer preload is max(d,1)-1.
    function automatic logic [CNT_WIDTH-1:0] dur_m1(input logic [CNT_WIDTH-1:0] d);
        return (d == '0) ? '0 : d - CNT_ONE;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] high_m1(input logic [CNT_WIDTH-1:0] len,
                                                     input logic [CNT_WIDTH-1:0] pw);
        return (len <= pw) ? '0 : len - pw - CNT_ONE;
    endfunction

    state_t state_q, state_d;
    sym_t   sym_q, sym_d;
    sym_t   next_sym;

    // The delimiter length is consumed in the start cycle itself, so it needs no latch.
    logic [CNT_WIDTH-1:0] tari_q, tari_d;
    logic [CNT_WIDTH-1:0] data1_q, data1_d;
    logic [CNT_WIDTH-1:0] rtcal_q, rtcal_d;
    logic [CNT_WIDTH-1:0] trcal_q, trcal_d;
    logic [CNT_WIDTH-1:0] pw_q, pw_d;
    logic                 pre_q, pre_d;

    logic cur_bit_q, cur_bit_d;
    logic cur_last_q, cur_last_d;
    logic hold_vld_q, hold_vld_d;
    logic hold_dat_q, hold_dat_d;
    logic hold_last_q, hold_last_d;
    logic last_acc_q, last_acc_d;

    logic tx_mod_q, tx_mod_d;
    logic busy_q, busy_d;
    logic bit_rdy_q, bit_rdy_d;
    logic done_q, done_d;
    logic err_q, err_d;

    logic                 accept;
    logic                 tmr_load;
    logic [CNT_WIDTH-1:0] tmr_val;
    logic [CNT_WIDTH-1:0] tmr_value_unused;
    logic                 tmr_expire;

    pie_symbol_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_value_unused),
        .expire   (tmr_expire)
    );

    assign accept = bit_vld & bit_rdy_q;

    always_comb begin
        state_d     = state_q;
        sym_d       = sym_q;
        next_sym    = SYM_DATA;
        tari_d      = tari_q;
        data1_d     = data1_q;
        rtcal_d     = rtcal_q;
        trcal_d     = trcal_q;
        pw_d        = pw_q;
        pre_d       = pre_q;
        cur_bit_d   = cur_bit_q;
        cur_last_d  = cur_last_q;
        hold_vld_d  = hold_vld_q;
        hold_dat_d  = hold_dat_q;
        hold_last_d = hold_last_q;
        last_acc_d  = last_acc_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        // Capture first so a bit arriving in the final LOW cycle still counts.
        if (accept) begin
            hold_vld_d  = 1'b1;
            hold_dat_d  = bit_dat;
            hold_last_d = bit_last;
            if (bit_last) begin
                last_acc_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tari_d     = cfg_tari;
                    data1_d    = cfg_data1;
                    rtcal_d    = cfg_rtcal;
                    trcal_d    = cfg_trcal;
                    pw_d       = cfg_pw;
                    pre_d      = preamble;
                    last_acc_d = 1'b0;
                    hold_vld_d = 1'b0;
                    state_d    = ST_DELIM;
                    tmr_load   = 1'b1;
                    tmr_val    = dur_m1(cfg_delim);
                end
            end
            ST_DELIM: begin
                if (tmr_expire) begin
                    state_d  = ST_HIGH;
                    sym_d    = SYM_DATA0;
                    tmr_load = 1'b1;
                    tmr_val  = high_m1(tari_q, pw_q);
                end
            end
            ST_HIGH: begin
                if (tmr_expire) begin
                    state_d  = ST_LOW;
                    tmr_load = 1'b1;
                    tmr_val  = dur_m1(pw_q);
                end
            end
            ST_LOW: begin
                if (tmr_expire) begin
                    case (sym_q)
                        SYM_DATA0: next_sym = SYM_RTCAL;
                        SYM_RTCAL: next_sym = pre_q ? SYM_TRCAL : SYM_DATA;
                        default:   next_sym = SYM_DATA;
                    endcase
                    if (sym_q == SYM_DATA && cur_last_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (next_sym == SYM_DATA && !hold_vld_d) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = ST_HIGH;
                        sym_d    = next_sym;
                        tmr_load = 1'b1;
                        case (next_sym)
                            SYM_RTCAL: tmr_val = high_m1(rtcal_q, pw_q);
                            SYM_TRCAL: tmr_val = high_m1(trcal_q, pw_q);
                            default: begin
                                cur_bit_d  = hold_dat_d;
                                cur_last_d = hold_last_d;
                                hold_vld_d = 1'b0;
                                tmr_val    = high_m1(hold_dat_d ? data1_q : tari_q, pw_q);
                            end
                        endcase
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d    = (state_d != ST_IDLE);
        tx_mod_d  = !(state_d == ST_DELIM || state_d == ST_LOW);
        bit_rdy_d = busy_d & ~hold_vld_d & ~last_acc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sym_q       <= SYM_DATA0;
            tari_q      <= '0;
            data1_q     <= '0;
            rtcal_q     <= '0;
            trcal_q     <= '0;
            pw_q        <= '0;
            pre_q       <= 1'b0;
            cur_bit_q   <= 1'b0;
            cur_last_q  <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_dat_q  <= 1'b0;
            hold_last_q <= 1'b0;
            last_acc_q  <= 1'b0;
            tx_mod_q    <= 1'b1;
            busy_q      <= 1'b0;
            bit_rdy_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_q       <= sym_d;
            tari_q      <= tari_d;
            data1_q     <= data1_d;
            rtcal_q     <= rtcal_d;
            trcal_q     <= trcal_d;
            pw_q        <= pw_d;
            pre_q       <= pre_d;
            cur_bit_q   <= cur_bit_d;
            cur_last_q  <= cur_last_d;
            hold_vld_q  <= hold_vld_d;
            hold_dat_q  <= hold_dat_d;
            hold_last_q <= hold_last_d;
            last_acc_q  <= last_acc_d;
            tx_mod_q    <= tx_mod_d;
            busy_q      <= busy_d;
            bit_rdy_q   <= bit_rdy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign tx_mod  = tx_mod_q;
    assign busy    = busy_q;
    assign bit_rdy = bit_rdy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_pie_encoder.sv
// Bench for pie_encoder: directed frames from the test plan plus random frames,
// each checked cycle by cycle against an envelope built from the symbol rules.
module tb_pie_encoder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] cfg_delim, cfg_tari, cfg_data1, cfg_rtcal, cfg_trcal, cfg_pw;
    logic         start = 1'b0;
    logic         preamble = 1'b0;
    logic         bit_dat = 1'b0;
    logic         bit_vld = 1'b0;
    logic         bit_last = 1'b0;
    logic         bit_rdy, tx_mod, busy, done, err;

    int total = 0;
    int bad = 0;
    int frame_no = 0;
    int done_cyc;
    bit bits_a[16];
    bit exp_q[$];

    pie_encoder #(.CNT_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_delim (cfg_delim),
        .cfg_tari  (cfg_tari),
        .cfg_data1 (cfg_data1),
        .cfg_rtcal (cfg_rtcal),
        .cfg_trcal (cfg_trcal),
        .cfg_pw    (cfg_pw),
        .start     (start),
        .preamble  (preamble),
        .bit_dat   (bit_dat),
        .bit_vld   (bit_vld),
        .bit_last  (bit_last),
        .bit_rdy   (bit_rdy),
        .tx_mod    (tx_mod),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // One symbol: carrier on for len-pw (at least 1), then pw low (at least 1).
    function automatic void push_sym(input int len);
        int pw = int'(cfg_pw);
        int hi = (len <= pw) ? 1 : len - pw;
        int lo = (pw == 0) ? 1 : pw;
        repeat (hi) exp_q.push_back(1'b1);
        repeat (lo) exp_q.push_back(1'b0);
    endfunction

    // Envelope for a frame whose first n_sent bits are delivered in time.
    function automatic void build_model(input bit pre, input int n_sent);
        int dl = (cfg_delim == '0) ? 1 : int'(cfg_delim);
        exp_q.delete();
        repeat (dl) exp_q.push_back(1'b0);
        push_sym(int'(cfg_tari));
        push_sym(int'(cfg_rtcal));
        if (pre) push_sym(int'(cfg_trcal));
        for (int i = 0; i < n_sent; i++) begin
            push_sym(bits_a[i] ? int'(cfg_data1) : int'(cfg_tari));
        end
    endfunction

    // Runs one frame of nbits, of which only 'supply' are ever offered.
    task automatic run_frame(input bit pre, input int nbits, input int supply,
                             input int ign_cyc, input bit chain, input bit chain_pre,
                             input bit pre_started);
        int n;
        int idx = 0;
        bit pv = 1'b0;
        bit pr = 1'b0;
        bit want_tx;
        build_model(pre, supply);
        n = exp_q.size();
        if (!pre_started) begin
            @(negedge clk);
            start = 1'b1;
            preamble = pre;
        end
        done_cyc = -1;
        for (int c = 1; c <= n + 1; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (pv && pr) idx++;
            want_tx = (c <= n) ? exp_q[c-1] : 1'b1;
            check($sformatf("f%0d tx_mod c%0d", frame_no, c), 32'(tx_mod), 32'(want_tx));
            check($sformatf("f%0d busy c%0d", frame_no, c), 32'(busy), 32'(c <= n));
            check($sformatf("f%0d done c%0d", frame_no, c), 32'(done), 32'(c == n + 1));
            check($sformatf("f%0d err c%0d", frame_no, c), 32'(err),
                  32'((c == n + 1) && (supply < nbits)));
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            if (c == ign_cyc) start = 1'b1;
            bit_vld  = (idx < supply) && (c <= n);
            bit_dat  = (idx < 16) ? bits_a[idx] : 1'b0;
            bit_last = (idx == nbits - 1);
            pv = bit_vld;
            pr = bit_rdy;
            if (c == n + 1 && chain) begin
                start = 1'b1;
                preamble = chain_pre;
            end
        end
        bit_vld = 1'b0;
        $display("frame %0d pre=%0d nbits=%0d supplied=%0d cycles=%0d done_at=%0d",
                 frame_no, pre, nbits, supply, n, done_cyc);
        frame_no++;
    endtask

    task automatic set_plan_cfg();
        cfg_delim = 16'd12;
        cfg_tari  = 16'd10;
        cfg_data1 = 16'd18;
        cfg_rtcal = 16'd28;
        cfg_trcal = 16'd56;
        cfg_pw    = 16'd5;
    endtask

    initial begin
        set_plan_cfg();
        repeat (3) @(negedge clk);
        check("rst tx_mod", 32'(tx_mod), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst bit_rdy", 32'(bit_rdy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Frame-sync 0,1 with a stray start at 40, chained into a preamble frame.
        bits_a[0] = 1'b0;
        bits_a[1] = 1'b1;
        run_frame(1'b0, 2, 2, 40, 1'b1, 1'b1, 1'b0);
        check("fs done cycle", 32'(done_cyc), 32'd79);
        run_frame(1'b1, 2, 2, 0, 1'b0, 1'b0, 1'b1);
        check("pre done cycle", 32'(done_cyc), 32'd135);

        // Underrun after a single non-last data-1 bit.
        bits_a[0] = 1'b1;
        run_frame(1'b0, 2, 1, 0, 1'b0, 1'b0, 1'b0);
        check("underrun done cycle", 32'(done_cyc), 32'd69);

        // Reset in cycle 30 of a frame.
        @(negedge clk);
        start = 1'b1;
        preamble = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 31) begin
                check("midrst tx_mod", 32'(tx_mod), 32'd1);
                check("midrst busy", 32'(busy), 32'd0);
                check("midrst bit_rdy", 32'(bit_rdy), 32'd0);
                check("midrst done", 32'(done), 32'd0);
                check("midrst err", 32'(err), 32'd0);
            end
            bit_vld  = (c < 30);
            bit_dat  = 1'b0;
            bit_last = 1'b0;
            rst      = (c == 30);
        end
        rst = 1'b0;
        bit_vld = 1'b0;
        $display("frame %0d reset at cycle 30", frame_no);
        frame_no++;
        bits_a[0] = 1'b0;
        bits_a[1] = 1'b1;
        run_frame(1'b0, 2, 2, 0, 1'b0, 1'b0, 1'b0);
        check("post-rst done cycle", 32'(done_cyc), 32'd79);

        // Pulse width longer than tari: data-0 HIGH collapses to one cycle.
        cfg_pw = 16'd12;
        bits_a[0] = 1'b0;
        run_frame(1'b0, 1, 1, 0, 1'b0, 1'b0, 1'b0);
        check("pw12 done cycle", 32'(done_cyc), 32'd67);

        // Random configurations, lengths, bit patterns and occasional underruns.
        for (int f = 0; f < 25; f++) begin
            int nb;
            int sup;
            bit pre;
            cfg_delim = 16'($urandom_range(1, 8));
            cfg_tari  = 16'($urandom_range(2, 8));
            cfg_data1 = cfg_tari + 16'($urandom_range(0, 6));
            cfg_rtcal = 16'($urandom_range(3, 15));
            cfg_trcal = 16'($urandom_range(3, 20));
            cfg_pw    = 16'($urandom_range(0, 6));
            nb  = int'($urandom_range(1, 5));
            sup = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : nb;
            pre = 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) bits_a[i] = 1'($urandom_range(0, 1));
            run_frame(pre, nb, sup, 0, 1'b0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
